// File: rtl/complex_mult_arbiter.sv
// Round-robin arbiter that time-shares one complex multiplier among NR_REQ requesters,
// routes each result back to its issuer and recovers a hung multiplier via a sw_rst pulse.
module complex_mult_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NR_REQ     = 4,
  parameter int RES_WIDTH  = 2*DATA_WIDTH+2,
  parameter int TIMEOUT    = 64,
  parameter int ID_W       = $clog2(NR_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_REQ-1:0]              req_val,
  input  logic [NR_REQ*4*DATA_WIDTH-1:0] req_data,
  output logic [NR_REQ-1:0]              req_ready,
  output logic [NR_REQ-1:0]              rsp_val,
  output logic [2*RES_WIDTH-1:0]         rsp_data,
  output logic                           rsp_err,
  output logic                           op_val,
  input  logic                           op_ready,
  output logic [4*DATA_WIDTH-1:0]        op_data,
  input  logic                           res_val,
  input  logic [2*RES_WIDTH-1:0]         res_data,
  output logic                           sw_rst,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  localparam int OPW = 4*DATA_WIDTH;
  localparam int TW  = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [ID_W-1:0]        grant_d;
  logic                   op_val_d;
  logic [OPW-1:0]         op_data_d;
  logic [NR_REQ-1:0]      req_ready_d, rsp_val_d;
  logic [2*RES_WIDTH-1:0] rsp_data_d;
  logic                   rsp_err_d, sw_rst_d;

  logic                   found;
  logic [ID_W-1:0]        win;
  logic [ID_W:0]          idx;
  logic                   timed_out;

  // Rotating priority: scan upward from the slot after the last completed grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= NR_REQ; i++) begin
      idx = {1'b0, last_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NR_REQ))
        idx = idx - (ID_W+1)'(NR_REQ);
      if (!found && req_val[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  assign timed_out = (timer_q == TW'(TIMEOUT-1));
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_d      = last_q;
    grant_d     = grant_id;
    op_val_d    = op_val;
    op_data_d   = op_data;
    req_ready_d = '0;
    rsp_val_d   = '0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    sw_rst_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_d = NR_REQ'(1) << win;
          op_data_d   = req_data[int'(win)*OPW +: OPW];
          op_val_d    = 1'b1;
          grant_d     = win;
          timer_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_q + TW'(1);
        if (timed_out) begin
          sw_rst_d   = 1'b1;
          op_val_d   = 1'b0;
          rsp_val_d  = NR_REQ'(1) << grant_id;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          last_d     = grant_id;
          state_d    = IDLE;
        end else if (op_ready) begin
          op_val_d = 1'b0;
          state_d  = WAIT_RES;
        end
      end
      WAIT_RES: begin
        timer_d = timer_q + TW'(1);
        // A result landing on the timeout cycle still counts as a success.
        if (res_val) begin
          rsp_val_d  = NR_REQ'(1) << grant_id;
          rsp_data_d = res_data;
          rsp_err_d  = 1'b0;
          last_d     = grant_id;
          state_d    = IDLE;
        end else if (timed_out) begin
          sw_rst_d   = 1'b1;
          op_val_d   = 1'b0;
          rsp_val_d  = NR_REQ'(1) << grant_id;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          last_d     = grant_id;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      last_q    <= ID_W'(NR_REQ-1);
      grant_id  <= '0;
      op_val    <= 1'b0;
      op_data   <= '0;
      req_ready <= '0;
      rsp_val   <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      sw_rst    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      grant_id  <= grant_d;
      op_val    <= op_val_d;
      op_data   <= op_data_d;
      req_ready <= req_ready_d;
      rsp_val   <= rsp_val_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      sw_rst    <= sw_rst_d;
    end
  end

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Directed bench: transaction-level reference model plus per-cycle compare and literal pins.
module tb_complex_mult_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int RW  = 2*DW+2;
  localparam int TO  = 64;
  localparam int OPW = 4*DW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_val = '0;
  logic [NR*OPW-1:0] req_data;
  logic [NR-1:0]     req_ready, rsp_val;
  logic [2*RW-1:0]   rsp_data;
  logic              rsp_err, op_val, sw_rst, busy;
  logic              op_ready = 1'b1;
  logic [OPW-1:0]    op_data;
  logic              res_val = 1'b0;
  logic [2*RW-1:0]   res_data = '0;
  logic [1:0]        grant_id;

  logic [OPW-1:0] slot [NR];
  assign req_data = {slot[3], slot[2], slot[1], slot[0]};

  always #5 clk = ~clk;

  complex_mult_arbiter #(.DATA_WIDTH(DW), .NR_REQ(NR), .RES_WIDTH(RW), .TIMEOUT(TO), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_data(req_data), .req_ready(req_ready),
    .rsp_val(rsp_val), .rsp_data(rsp_data), .rsp_err(rsp_err), .op_val(op_val),
    .op_ready(op_ready), .op_data(op_data), .res_val(res_val), .res_data(res_data),
    .sw_rst(sw_rst), .busy(busy), .grant_id(grant_id)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one outstanding job, counted in cycles since its grant.
  logic [NR-1:0]   exp_req_ready = '0, exp_rsp_val = '0;
  logic [2*RW-1:0] exp_rsp_data = '0;
  logic            exp_rsp_err = 1'b0, exp_op_val = 1'b0, exp_sw_rst = 1'b0;
  logic [OPW-1:0]  exp_op_data = '0;
  logic [1:0]      exp_grant = '0;
  logic            m_busy = 1'b0, m_xfer = 1'b0;
  int              m_age = 0;
  int              m_last = NR-1;

  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int i = 1; i <= NR; i++)
      if (v[(last+i)%NR]) return (last+i)%NR;
    return 0;
  endfunction

  function automatic logic [OPW-1:0] slot_of(input int k);
    return req_data[k*OPW +: OPW];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_req_ready <= '0; exp_rsp_val <= '0; exp_rsp_data <= '0; exp_rsp_err <= 1'b0;
      exp_op_val <= 1'b0; exp_op_data <= '0; exp_sw_rst <= 1'b0; exp_grant <= '0;
      m_busy <= 1'b0; m_xfer <= 1'b0; m_age <= 0; m_last <= NR-1;
    end else begin
      exp_req_ready <= '0;
      exp_rsp_val   <= '0;
      exp_sw_rst    <= 1'b0;
      if (!m_busy) begin
        if (req_val != '0) begin
          exp_grant     <= 2'(pick(req_val, m_last));
          exp_req_ready <= 4'(1) << pick(req_val, m_last);
          exp_op_data   <= slot_of(pick(req_val, m_last));
          exp_op_val    <= 1'b1;
          m_busy <= 1'b1; m_xfer <= 1'b0; m_age <= 0;
        end
      end else begin
        m_age <= m_age + 1;
        if (m_xfer && res_val) begin
          exp_rsp_val <= 4'(1) << exp_grant; exp_rsp_data <= res_data; exp_rsp_err <= 1'b0;
          m_last <= int'(exp_grant); m_busy <= 1'b0;
        end else if (m_age + 1 == TO) begin
          exp_rsp_val <= 4'(1) << exp_grant; exp_rsp_data <= '0; exp_rsp_err <= 1'b1;
          exp_sw_rst <= 1'b1; exp_op_val <= 1'b0;
          m_last <= int'(exp_grant); m_busy <= 1'b0;
        end else if (!m_xfer && op_ready) begin
          m_xfer <= 1'b1; exp_op_val <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare and event logs.
  int             glog[$];
  int             rlog[$];
  int             cyc = 0, g_cyc = 0, r_cyc = 0, s_cyc = 0, sw_cnt = 0;
  logic [OPW-1:0] g_op = '0;
  logic [2*RW-1:0] r_data = '0;
  logic           r_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("req_ready", req_ready, exp_req_ready);
      chk("rsp_val", rsp_val, exp_rsp_val);
      if (exp_rsp_val != '0) begin
        chk("rsp_data", rsp_data, exp_rsp_data);
        chk("rsp_err", rsp_err, exp_rsp_err);
      end
      chk("op_val", op_val, exp_op_val);
      if (exp_op_val) chk("op_data", op_data, exp_op_data);
      chk("sw_rst", sw_rst, exp_sw_rst);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, exp_grant);
      if (req_ready != '0) begin glog.push_back(int'(grant_id)); g_cyc = cyc; g_op = op_data; end
      if (rsp_val != '0) begin
        for (int i = 0; i < NR; i++) if (rsp_val[i]) rlog.push_back(i);
        r_cyc = cyc; r_data = rsp_data; r_err = rsp_err;
      end
      if (sw_rst) begin sw_cnt++; s_cyc = cyc; end
    end
  end

  // Multiplier stand-in: result mul_lat cycles after transfer; mul_lat = 0 hangs until sw_rst.
  int             mul_lat = 3;
  logic           op_block = 1'b0;
  logic           mbusy = 1'b0, xfer, clr;
  int             cnt = 0;
  logic [OPW-1:0] opl = '0;

  initial begin
    forever begin
      int a, b, c, d;
      @(negedge clk);
      xfer = op_val && op_ready && !rst;
      clr  = sw_rst || rst;
      @(posedge clk); #1;
      res_val = 1'b0;
      if (clr || rst) mbusy = 1'b0;
      else if (xfer) begin mbusy = 1'b1; cnt = mul_lat; opl = op_data; op_ready = 1'b0; end
      if (mbusy && mul_lat != 0) begin
        cnt--;
        if (cnt == 0) begin
          a = int'($signed(opl[31:24])); b = int'($signed(opl[23:16]));
          c = int'($signed(opl[15:8]));  d = int'($signed(opl[7:0]));
          res_data = {RW'(a*c - b*d), RW'(a*d + b*c)};
          res_val  = 1'b1;
          mbusy    = 1'b0;
        end
      end
      if (!mbusy) op_ready = !op_block;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0); chk({tag, "_rsp_val"}, rsp_val, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);   chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_op_val"}, op_val, 0);       chk({tag, "_op_data"}, op_data, 0);
    chk({tag, "_sw_rst"}, sw_rst, 0);       chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  task automatic clear_logs();
    glog.delete(); rlog.delete(); sw_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_val = '0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic issue_one(input int k, input int maxc);
    logic got = 1'b0;
    req_val[k] = 1'b1;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); #1;
      if (req_ready[k]) begin req_val[k] = 1'b0; got = 1'b1; end
    end
    req_val[k] = 1'b0;
    chk("grant_seen", got, 1);
  endtask

  task automatic wait_rsp(input int maxc);
    int n = rlog.size();
    for (int i = 0; i < maxc && rlog.size() == n; i++) begin @(negedge clk); #1; end
    chk("rsp_seen", rlog.size() > n, 1);
  endtask

  task automatic wait_grants(input int n, input int maxc);
    for (int i = 0; i < maxc && glog.size() < n; i++) begin @(negedge clk); #1; end
    chk("grant_count", glog.size() >= n, 1);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) begin @(negedge clk); #1; end
    chk("idle", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < NR; i++) slot[i] = '0;
    #1 rst = 1'b1;
    do_reset();

    // Single request (2+3i)*(4+2i) = 2+16i
    mul_lat = 3;
    slot[0] = 32'h02030402;
    issue_one(0, 20);
    wait_rsp(20);
    chk("single_op_data", g_op, 32'h02030402);
    chk("single_rsp_idx", rlog[0], 0);
    chk("single_rsp_data", r_data, {18'd2, 18'd16});
    chk("single_rsp_err", r_err, 0);
    chk("single_latency", r_cyc - g_cyc, 4);
    chk("single_busy_after", busy, 0);

    // All four requesting continuously
    do_reset();
    mul_lat = 2;
    slot[0] = 32'h01010101; slot[1] = 32'h02010302; slot[2] = 32'hff020103; slot[3] = 32'h04fd0205;
    req_val = 4'hf;
    wait_grants(5, 200);
    req_val = '0;
    wait_idle(100);
    chk("rr4_g0", glog[0], 0); chk("rr4_g1", glog[1], 1); chk("rr4_g2", glog[2], 2);
    chk("rr4_g3", glog[3], 3); chk("rr4_g4", glog[4], 0);
    chk("rr4_r0", rlog[0], 0); chk("rr4_r1", rlog[1], 1); chk("rr4_r2", rlog[2], 2);
    chk("rr4_r3", rlog[3], 3);

    // Requesters 1 and 3 only
    do_reset();
    req_val = 4'b1010;
    wait_grants(4, 200);
    req_val = '0;
    wait_idle(100);
    chk("rr2_g0", glog[0], 1); chk("rr2_g1", glog[1], 3);
    chk("rr2_g2", glog[2], 1); chk("rr2_g3", glog[3], 3);
    begin
      int other = 0;
      foreach (glog[i]) if (glog[i] == 0 || glog[i] == 2) other++;
      chk("rr2_no_0_or_2", other, 0);
    end

    // Hung multiplier: watchdog
    do_reset();
    mul_lat = 0;
    slot[2] = 32'h01010101;
    issue_one(2, 20);
    wait_rsp(100);
    chk("to_sw_rst_delay", s_cyc - g_cyc, 64);
    chk("to_sw_rst_count", sw_cnt, 1);
    chk("to_rsp_idx", rlog[0], 2);
    chk("to_rsp_err", r_err, 1);
    chk("to_rsp_data", r_data, 0);
    mul_lat = 2;
    slot[0] = 32'h03010102;
    issue_one(0, 20);
    wait_rsp(30);
    chk("after_to_idx", rlog[1], 0);
    chk("after_to_err", r_err, 0);
    chk("after_to_data", r_data, {18'd1, 18'd7});
    chk("after_to_sw_count", sw_cnt, 1);

    // Result on the timeout cycle wins: (1+2i)*(3+4i) = -5+10i
    do_reset();
    mul_lat = 63;
    slot[3] = 32'h01020304;
    issue_one(3, 20);
    wait_rsp(100);
    chk("edge_rsp_err", r_err, 0);
    chk("edge_sw_count", sw_cnt, 0);
    chk("edge_latency", r_cyc - g_cyc, 64);
    chk("edge_rsp_data", r_data, {18'h3fffb, 18'd10});

    // op_ready stall, then reset during WAIT_RES
    do_reset();
    op_block = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mul_lat = 20;
    slot[1] = 32'h05060708;
    issue_one(1, 20);
    repeat (10) begin
      @(negedge clk);
      chk("stall_op_val", op_val, 1);
      chk("stall_op_data", op_data, 32'h05060708);
    end
    op_block = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_op_val", op_val, 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    clear_logs();
    repeat (25) begin @(negedge clk); #1; end
    chk("abort_no_rsp", rlog.size(), 0);
    req_val = 4'b0011;
    wait_grants(1, 20);
    req_val = '0;
    wait_idle(60);
    chk("abort_next_grant", glog[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
